// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, reads imem over req/ack, buffers {pc, instr} for ctrl.
// Optional FETCH_BYPASS_EN forwards the returned word straight to cmd when the buffer is empty.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] cmd,
  output logic [31:0] cmd_pc,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_fpc;
  logic [5:0]      r_disc_addr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [31:0]     r_pc_mem  [DEPTH];
  logic [31:0]     r_ins_mem [DEPTH];

  logic            w_full;
  logic            w_empty;
  logic            w_acc;
  logic            w_byp;
  logic            w_head_vld;
  logic            w_push;
  logic            w_pop;
  logic            w_abandon;
  logic [31:0]     w_redirect_fpc;

  assign w_full         = (r_count == FULL_CNT);
  assign w_empty        = (r_count == '0);
  assign w_redirect_fpc = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    imem_addr   = r_fpc[7:2];
    w_abandon   = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = !w_full && !rst;
        // A redirect that catches a request in flight must still wait out its ack.
        if (redirect && imem_req && !imem_ack) begin
          w_abandon   = 1'b1;
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        imem_req  = !rst;
        imem_addr = r_disc_addr;
        if (imem_ack) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign w_acc = (r_state == S_FETCH) && imem_req && imem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_acc && w_empty;
`else
  assign w_byp = 1'b0;
`endif

  assign w_head_vld = !w_empty && !rst;
  assign cmd_valid  = w_head_vld || w_byp;
  assign w_pop      = w_head_vld && cmd_ready && !redirect;
  assign w_push     = w_acc && !(w_byp && cmd_ready);

  always_comb begin
    cmd    = 32'h0;
    cmd_pc = 32'h0;
    if (w_byp) begin
      cmd    = imem_rdata;
      cmd_pc = r_fpc;
    end else if (w_head_vld) begin
      cmd    = r_ins_mem[r_rd_ptr];
      cmd_pc = r_pc_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_fpc       <= RESET_PC;
      r_disc_addr <= 6'd0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect) begin
        r_fpc    <= w_redirect_fpc;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        if (w_abandon) begin
          r_disc_addr <= r_fpc[7:2];
        end
      end else begin
        if (w_acc) begin
          r_fpc <= r_fpc + 32'd4;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload storage needs no reset: cmd/cmd_pc are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_fpc;
      r_ins_mem[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule
